pi_ctrl_top: RTL and testbench

PI_CTRL_TOP -- requirements
Module: pi_ctrl_top

---
 rtl/pi_ctrl_top.sv | 113 +++++++++++
 tb/tb_pi_ctrl_top.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_ctrl_top.sv
// pi_ctrl_top: closed-loop PI controller driving an internal first-order plant.
//
// The controller error is ref_i minus the plant output. The PI law adds a
// proportional term to a clamped integrator and clamps the sum, which gives u.
// The plant y low-pass filters u with time constant 2^PLANT_SHIFT cycles.
// All arithmetic saturates, so no ref_i value can wrap any stage.
//
// Ports:
//   clk    in   1          sole clock, rising edge
//   rst_n  in   1          asynchronous active-low reset
//   ref_i  in   32 signed  setpoint, sampled every cycle
//   err_o  out  32 signed  registered error  (ref_i - y)
//   u_o    out  32 signed  registered controller output
//   y_o    out  32 signed  registered plant output (feedback)
//   sat_o  out  1          u_o of this cycle was clamped
module pi_ctrl_top #(
  parameter int KP_Q8       = 128,
  parameter int KI_Q8       = 4,
  parameter int OUT_MAX     = 100000,
  parameter int PLANT_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] ref_i,
  output logic signed [31:0] err_o,
  output logic signed [31:0] u_o,
  output logic signed [31:0] y_o,
  output logic               sat_o
);

  localparam logic signed [47:0] KP_S  = 48'(KP_Q8);
  localparam logic signed [47:0] KI_S  = 48'(KI_Q8);
  localparam logic signed [47:0] U_MAX = 48'(OUT_MAX);
  localparam logic signed [47:0] U_MIN = -48'(OUT_MAX);
  localparam logic signed [48:0] I_MAX = 49'(OUT_MAX) * 49'sd256;
  localparam logic signed [48:0] I_MIN = -(49'(OUT_MAX) * 49'sd256);

  logic signed [31:0] err_q, u_q, y_q;
  logic signed [47:0] integ_q;
  logic               sat_q;

  logic signed [31:0] err_next, u_next, y_next;
  logic signed [47:0] integ_next;
  logic               sat_next;

  logic signed [32:0] e_diff;
  logic signed [47:0] err_ext, ki_term, kp_term, pi_sum, pi_shift;
  logic signed [48:0] integ_sum;
  logic signed [32:0] p_diff, p_step, y_sum;
  logic               unused_bits;

  always_comb begin
    // Error: the 33-bit difference overflows 32 bits exactly when its two
    // top bits disagree; the sign bit then picks the rail.
    e_diff   = {ref_i[31], ref_i} - {y_q[31], y_q};
    err_next = e_diff[31:0];
    if (e_diff[32] != e_diff[31])
      err_next = e_diff[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;

    err_ext = {{16{err_q[31]}}, err_q};

    // Integrator (Q8): the clamp is the only anti-windup.
    ki_term    = KI_S * err_ext;
    integ_sum  = {integ_q[47], integ_q} + {ki_term[47], ki_term};
    integ_next = integ_sum[47:0];
    if (integ_sum > I_MAX)      integ_next = I_MAX[47:0];
    else if (integ_sum < I_MIN) integ_next = I_MIN[47:0];

    // Output uses the integrator value from before this edge's update.
    kp_term  = KP_S * err_ext;
    pi_sum   = kp_term + integ_q;
    pi_shift = pi_sum >>> 8;
    u_next   = pi_shift[31:0];
    sat_next = 1'b0;
    if (pi_shift > U_MAX) begin
      u_next   = U_MAX[31:0];
      sat_next = 1'b1;
    end else if (pi_shift < U_MIN) begin
      u_next   = U_MIN[31:0];
      sat_next = 1'b1;
    end

    // Plant: y moves toward u, so it stays within the u rails and fits 32 bits.
    p_diff = {u_q[31], u_q} - {y_q[31], y_q};
    p_step = p_diff >>> PLANT_SHIFT;
    y_sum  = {y_q[31], y_q} + p_step;
    y_next = y_sum[31:0];

    unused_bits = ^{pi_shift[47:32], y_sum[32]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= '0;
      integ_q <= '0;
      u_q     <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      err_q   <= err_next;
      integ_q <= integ_next;
      u_q     <= u_next;
      y_q     <= y_next;
      sat_q   <= sat_next;
    end
  end

  assign err_o = err_q;
  assign u_o   = u_q;
  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: tb/tb_pi_ctrl_top.sv
module tb_pi_ctrl_top;

  logic               clk;
  logic               rst_n;
  logic signed [31:0] ref_i;
  logic signed [31:0] err_o, u_o, y_o;
  logic               sat_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic signed [31:0] POS_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] NEG_MIN = 32'sh8000_0000;
  localparam logic signed [47:0] I_LIM   = 48'sd25600000;

  pi_ctrl_top #(
    .KP_Q8(128),
    .KI_Q8(4),
    .OUT_MAX(100000),
    .PLANT_SHIFT(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ref_i(ref_i),
    .err_o(err_o),
    .u_o  (u_o),
    .y_o  (y_o),
    .sat_o(sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across an edge, then release 1 unit after it so that the
  // next rising edge is the first state update.
  task automatic apply_reset(input logic signed [31:0] r);
    rst_n = 1'b0;
    ref_i = r;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ref_i = 32'sd350;
    #2;
    checks++;
    if ({err_o, u_o, y_o, sat_o} !== '0) begin
      errors++;
      $display("FAIL reset_zero: err=%0d u=%0d y=%0d sat=%b required all 0", err_o, u_o, y_o, sat_o);
    end
    tick();
    rst_n = 1'b1;
  endtask

  // Checks the first four edges after reset with ref_i = 350.
  task automatic check_step_start(input string tag);
    tick();
    checks++;
    if (err_o !== 32'sd350 || u_o !== 32'sd0 || y_o !== 32'sd0) begin
      errors++;
      $display("FAIL %s_e1: err=%0d u=%0d y=%0d required 350 0 0", tag, err_o, u_o, y_o);
    end
    tick();
    checks++;
    if (u_o !== 32'sd175 || sat_o !== 1'b0 || y_o !== 32'sd0) begin
      errors++;
      $display("FAIL %s_e2: u=%0d sat=%b y=%0d required 175 0 0", tag, u_o, sat_o, y_o);
    end
    tick();
    checks++;
    if (u_o !== 32'sd180 || y_o !== 32'sd21 || err_o !== 32'sd350) begin
      errors++;
      $display("FAIL %s_e3: u=%0d y=%0d err=%0d required 180 21 350", tag, u_o, y_o, err_o);
    end
    tick();
    checks++;
    if (err_o !== 32'sd329 || u_o !== 32'sd185 || y_o !== 32'sd40) begin
      errors++;
      $display("FAIL %s_e4: err=%0d u=%0d y=%0d required 329 185 40", tag, err_o, u_o, y_o);
    end
  endtask

  task automatic test_step();
    logic signed [31:0] prev;
    int unsigned drops;
    int unsigned sats;
    apply_reset(32'sd350);
    check_step_start("step");
    prev  = y_o;
    drops = 0;
    sats  = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (y_o < prev) drops++;
      if (sat_o !== 1'b0) sats++;
      prev = y_o;
    end
    checks++;
    if (drops != 0 || sats != 0) begin
      errors++;
      $display("FAIL step_monotonic: drops=%0d sat_cycles=%0d required 0 0", drops, sats);
    end
  endtask

  task automatic test_settling();
    logic signed [31:0] dy;
    for (int i = 0; i < 1000; i++) tick();
    dy = y_o - 32'sd350;
    checks++;
    if (dy > 8 || dy < -8 || err_o > 8 || err_o < -8) begin
      errors++;
      $display("FAIL settle_350: y=%0d err=%0d required |y-350|<=8 |err|<=8", y_o, err_o);
    end
    checks++;
    if ((^{err_o, u_o, y_o, sat_o}) === 1'bx || dut.integ_q > I_LIM || dut.integ_q < -I_LIM) begin
      errors++;
      $display("FAIL settle_sane: integ=%0d outputs=%h %h %h %b required known and within limit",
               dut.integ_q, err_o, u_o, y_o, sat_o);
    end
  endtask

  task automatic test_saturation();
    apply_reset(POS_MAX);
    tick();
    checks++;
    if (err_o !== POS_MAX) begin
      errors++;
      $display("FAIL sat_err: err=%0d required %0d", err_o, POS_MAX);
    end
    tick();
    checks++;
    if (u_o !== 32'sd100000 || sat_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_u: u=%0d sat=%b required 100000 1", u_o, sat_o);
    end
    for (int i = 0; i < 198; i++) tick();
    checks++;
    if (y_o < 32'sd99992 || y_o > 32'sd100000 || u_o !== 32'sd100000 || sat_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_conv: y=%0d u=%0d sat=%b required y in [99992,100000] u 100000 sat 1",
               y_o, u_o, sat_o);
    end
    checks++;
    if (dut.integ_q !== I_LIM) begin
      errors++;
      $display("FAIL sat_integ: integ=%0d required %0d", dut.integ_q, I_LIM);
    end
  endtask

  // Continues straight from the saturated state.
  task automatic test_antiwindup();
    logic signed [31:0] dy;
    ref_i = -32'sd350;
    tick();
    checks++;
    if (u_o !== 32'sd100000 || dut.integ_q !== I_LIM) begin
      errors++;
      $display("FAIL aw_e1: u=%0d integ=%0d required 100000 %0d", u_o, dut.integ_q, I_LIM);
    end
    tick();
    checks++;
    if (!(dut.integ_q < I_LIM) || !(u_o < 32'sd100000) || !(u_o > 32'sd0) || sat_o !== 1'b0) begin
      errors++;
      $display("FAIL aw_e2: u=%0d sat=%b integ=%0d required 0<u<100000 sat 0 integ below limit",
               u_o, sat_o, dut.integ_q);
    end
    for (int i = 0; i < 1500; i++) tick();
    dy = y_o + 32'sd350;
    checks++;
    if (dy > 8 || dy < -8) begin
      errors++;
      $display("FAIL aw_settle: y=%0d required -350+-8", y_o);
    end
  endtask

  task automatic test_extreme();
    apply_reset(32'sd350);
    tick();
    tick();
    tick();
    checks++;
    if (y_o !== 32'sd21) begin
      errors++;
      $display("FAIL ext_pre: y=%0d required 21", y_o);
    end
    ref_i = NEG_MIN;
    tick();
    checks++;
    if (err_o !== NEG_MIN) begin
      errors++;
      $display("FAIL ext_err: err=%0d required %0d", err_o, NEG_MIN);
    end
    tick();
    checks++;
    if (u_o !== -32'sd100000 || sat_o !== 1'b1) begin
      errors++;
      $display("FAIL ext_u: u=%0d sat=%b required -100000 1", u_o, sat_o);
    end
  endtask

  task automatic test_midrun_reset();
    apply_reset(32'sd350);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (y_o == 32'sd0) begin
      errors++;
      $display("FAIL mid_pre: y=%0d required nonzero", y_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({err_o, u_o, y_o, sat_o} !== '0 || dut.integ_q !== 48'sd0) begin
      errors++;
      $display("FAIL mid_reset: err=%0d u=%0d y=%0d sat=%b integ=%0d required all 0",
               err_o, u_o, y_o, sat_o, dut.integ_q);
    end
    tick();
    rst_n = 1'b1;
    check_step_start("restart");
  endtask

  initial begin
    rst_n = 1'b0;
    ref_i = '0;
    test_reset();
    test_step();
    test_settling();
    test_saturation();
    test_antiwindup();
    test_extreme();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
